// File: rtl/proc_seq_pkg.sv
// rtl/proc_seq_pkg.sv - shared Gray/binary helpers and processor stage codes
package proc_seq_pkg;

  localparam int SEQ_MAX_W = 16;

  // Processor 2-bit stage codes (Gray order: fetch -> decode -> exec -> wb)
  localparam logic [1:0] STG_FETCH  = 2'b00;
  localparam logic [1:0] STG_DECODE = 2'b01;
  localparam logic [1:0] STG_EXEC   = 2'b11;
  localparam logic [1:0] STG_WB     = 2'b10;

  function automatic logic [SEQ_MAX_W-1:0] bin2gray(input logic [SEQ_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [SEQ_MAX_W-1:0] gray2bin(input logic [SEQ_MAX_W-1:0] g);
    logic [SEQ_MAX_W-1:0] b;
    b[SEQ_MAX_W-1] = g[SEQ_MAX_W-1];
    for (int i = SEQ_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_counter.sv
// rtl/gray_seq_counter.sv - parametrised up/down Gray-code sequencer with load, tc and wrap
module gray_seq_counter
  import proc_seq_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [WIDTH-1:0]     gray_q, gray_d;
  logic                 wrap_q, wrap_d;
  logic [SEQ_MAX_W-1:0] gray_full;

  assign tc = up_dn ? (bin_q == ALL_ONES) : (bin_q == ZERO);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (clk_en) begin
      bin_d  = up_dn ? (bin_q + ONE) : (bin_q - ONE);
      wrap_d = tc;
    end
  end

  // Gray is derived from the next binary index so both registers always agree
  assign gray_full = bin2gray(SEQ_MAX_W'(bin_d));
  assign gray_d    = gray_full[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_seq_counter.sv
// tb/tb_gray_seq_counter.sv - self-checking bench for gray_seq_counter (WIDTH 2 and 4)
module tb_gray_seq_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2, en2, up2, ld2;
  logic [1:0] lv2, g2, b2;
  logic       tc2, wr2;
  logic       rst4, en4, up4, ld4;
  logic [3:0] lv4, g4, b4;
  logic       tc4, wr4;

  gray_seq_counter #(.WIDTH(2), .RESET_VALUE(0)) dut2 (
    .clk(clk), .reset(rst2), .clk_en(en2), .up_dn(up2), .load(ld2), .load_val(lv2),
    .gray_out(g2), .bin_out(b2), .tc(tc2), .wrap(wr2)
  );

  gray_seq_counter #(.WIDTH(4), .RESET_VALUE(5)) dut4 (
    .clk(clk), .reset(rst4), .clk_en(en4), .up_dn(up4), .load(ld4), .load_val(lv4),
    .gray_out(g4), .bin_out(b4), .tc(tc4), .wrap(wr4)
  );

  int n_checks = 0;
  int n_err    = 0;
  int i2, i4;
  bit w2m, w4m;
  int wraps4_obs, wraps4_exp;

  // Reflected-binary construction: second half is the mirrored first half with the top bit set
  function automatic int refl_gray(input int w, input int idx);
    int half;
    if (w == 1) return idx;
    half = 1 << (w - 1);
    if (idx < half) return refl_gray(w - 1, idx);
    return half | refl_gray(w - 1, 2 * half - 1 - idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int n, input int rv, input bit rst, input bit ld,
                            input bit en, input bit up, input int lv,
                            inout int idx, inout bit w);
    if (rst) begin
      idx = rv; w = 1'b0;
    end else if (ld) begin
      idx = lv; w = 1'b0;
    end else if (en) begin
      w   = up ? (idx == n - 1) : (idx == 0);
      idx = up ? (idx + 1) % n : (idx + n - 1) % n;
    end else begin
      w = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("bin2",  32'(b2),  32'(i2));
    chk("gray2", 32'(g2),  32'(refl_gray(2, i2)));
    chk("tc2",   32'(tc2), 32'(up2 ? (i2 == 3) : (i2 == 0)));
    chk("wrap2", 32'(wr2), 32'(w2m));
    chk("bin4",  32'(b4),  32'(i4));
    chk("gray4", 32'(g4),  32'(refl_gray(4, i4)));
    chk("tc4",   32'(tc4), 32'(up4 ? (i4 == 15) : (i4 == 0)));
    chk("wrap4", 32'(wr4), 32'(w4m));
  endtask

  task automatic tick();
    logic [3:0] gprev;
    bit stepped4;
    gprev    = g4;
    stepped4 = en4 && !ld4 && !rst4;
    model_step(4,  0, rst2, ld2, en2, up2, int'(lv2), i2, w2m);
    model_step(16, 5, rst4, ld4, en4, up4, int'(lv4), i4, w4m);
    @(posedge clk);
    #1;
    check_all();
    if (stepped4) chk("gray4_onebit", 32'($countones(gprev ^ g4)), 32'd1);
    if (wr4) wraps4_obs++;
    if (w4m) wraps4_exp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst2 = 1'b1; en2 = 1'b0; up2 = 1'b1; ld2 = 1'b0; lv2 = '0;
    rst4 = 1'b1; en4 = 1'b0; up4 = 1'b1; ld4 = 1'b0; lv4 = '0;
    #2;
    i2 = 0; w2m = 1'b0; i4 = 5; w4m = 1'b0;
    check_all();
    chk("rst_gray4_0111", 32'(g4), 32'h7);
    @(posedge clk); #1;
    rst2 = 1'b0; rst4 = 1'b0;

    // Up count through a full cycle and back to 00
    en2 = 1'b1; up2 = 1'b1;
    repeat (5) tick();
    tick();
    chk("t2_at_11", 32'(g2), 32'h3);

    // Hold at 11
    en2 = 1'b0;
    repeat (3) tick();
    en2 = 1'b1;
    tick();
    chk("t2_resume_10", 32'(g2), 32'h2);
    tick();

    // Down count from 00
    up2 = 1'b0;
    repeat (4) tick();

    // Load, then load beats an enabled wrap step
    en2 = 1'b0; ld2 = 1'b1; lv2 = 2'd2;
    tick();
    chk("t4_load_gray11", 32'(g2), 32'h3);
    lv2 = 2'd3;
    tick();
    en2 = 1'b1; up2 = 1'b1; lv2 = 2'd0;
    tick();
    chk("t4_load_prio_wrap0", 32'(wr2), 32'd0);
    ld2 = 1'b0;

    // Async reset between edges at gray=10
    repeat (3) tick();
    #3;
    rst2 = 1'b1;
    #1;
    i2 = 0; w2m = 1'b0;
    check_all();
    tick();
    #2;
    rst2 = 1'b0;
    tick();
    chk("t5_resume_01", 32'(g2), 32'h1);
    en2 = 1'b0;

    // WIDTH=4: 40 up then 40 down steps
    wraps4_obs = 0; wraps4_exp = 0;
    en4 = 1'b1; up4 = 1'b1;
    repeat (40) tick();
    up4 = 1'b0;
    repeat (40) tick();
    chk("t6_wrap_count", 32'(wraps4_obs), 32'(wraps4_exp));
    chk("t6_wrap_count_abs", 32'(wraps4_obs), 32'd4);

    // Randomised mix on both instances
    for (int k = 0; k < 120; k++) begin
      en2 = 1'($urandom_range(0, 3) != 0);
      up2 = 1'($urandom);
      ld2 = 1'($urandom_range(0, 7) == 0);
      lv2 = 2'($urandom);
      en4 = 1'($urandom_range(0, 3) != 0);
      up4 = 1'($urandom);
      ld4 = 1'($urandom_range(0, 7) == 0);
      lv4 = 4'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
